// File: rtl/dcache_store_buffer.sv
// Store buffer between MEM and the data cache write port: aligns committed stores
// into byte-lane enables / shifted data, queues them, and flags overlapping loads.

module dcache_sb_match #(
  parameter int ADDR_W = 32,
  parameter int BE     = 4
) (
  input  logic              vld,
  input  logic [ADDR_W-1:0] entAddr,
  input  logic [BE-1:0]     entWen,
  input  logic [ADDR_W-1:0] ldAddr,
  input  logic [BE-1:0]     ldMask,
  output logic              hit
);
  assign hit = vld && (entAddr == ldAddr) && |(entWen & ldMask);
endmodule

module dcache_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               req_size,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     cache_req_valid,
  input  logic                     cache_req_ready,
  output logic [ADDR_W-1:0]        cache_addr,
  output logic [DATA_W/8-1:0]      cache_wen,
  output logic [DATA_W-1:0]        cache_wdata,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [1:0]               ld_size,
  output logic                     ld_conflict,
  output logic                     st_addr_err,
  output logic [ADDR_W-1:0]        st_err_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int BE  = DATA_W / 8;
  localparam int OFF = $clog2(BE);
  localparam int PW  = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE-1:0]     wen;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic   [DEPTH-1:0] entVld;
  logic   [PW-1:0]    head, tail;

  function automatic logic [BE-1:0] sizeMask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m[BE-1:0];
  endfunction

  // Size 11 can never be aligned on a 32-bit cache.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return |a[1:0];
      default: return (DATA_W == 32) || (|a);
    endcase
  endfunction

  logic [OFF-1:0]    reqOff;
  logic [BE-1:0]     reqMask, ldMask;
  logic [DATA_W-1:0] reqData;
  logic [ADDR_W-1:0] reqAlign, ldAlign;
  logic              accept, reqMis, enq, deq;

  assign reqOff   = req_addr[OFF-1:0];
  assign reqMask  = sizeMask(req_size) << reqOff;
  assign reqData  = req_wdata << {reqOff, 3'b000};
  assign reqAlign = {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign ldMask   = sizeMask(ld_size) << ld_addr[OFF-1:0];
  assign ldAlign  = {ld_addr[ADDR_W-1:OFF], {OFF{1'b0}}};

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign reqMis    = misaligned(req_size, req_addr[2:0]);
  assign enq       = accept && !reqMis;
  assign deq       = cache_req_valid && cache_req_ready;

  assign cache_req_valid = entVld[head];
  assign cache_addr      = ent[head].addr;
  assign cache_wen       = ent[head].wen;
  assign cache_wdata     = ent[head].data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent         <= '0;
      entVld      <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      st_addr_err <= 1'b0;
      st_err_addr <= '0;
    end else begin
      // tail==head only when empty or full, so these never touch the same slot.
      if (enq) begin
        ent[tail]    <= '{addr: reqAlign, wen: reqMask, data: reqData};
        entVld[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      if (deq) begin
        entVld[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      count       <= count + (PW+1)'(enq) - (PW+1)'(deq);
      st_addr_err <= accept && reqMis;
      if (accept && reqMis) st_err_addr <= req_addr;
    end
  end

  logic [DEPTH-1:0] hitVec;

  for (genvar i = 0; i < DEPTH; i++) begin : gMatch
    dcache_sb_match #(.ADDR_W(ADDR_W), .BE(BE)) uMatch (
      .vld     (entVld[i]),
      .entAddr (ent[i].addr),
      .entWen  (ent[i].wen),
      .ldAddr  (ldAlign),
      .ldMask  (ldMask),
      .hit     (hitVec[i])
    );
  end

  assign ld_conflict = ld_valid && (|hitVec);
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed bench: a 32-bit and a 64-bit store buffer instance, hand-computed expectations.

module tb_dcache_store_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 32-bit instance (prefix a), 64-bit instance (prefix b)
  logic        aRstn, aReqValid, aReqReady, aCacheValid, aCacheReady, aLdValid, aLdConf, aErr;
  logic [31:0] aReqAddr, aReqData, aCacheAddr, aCacheData, aLdAddr, aErrAddr;
  logic [1:0]  aReqSize, aLdSize;
  logic [3:0]  aWen;
  logic [2:0]  aCount;
  logic        aEmpty, aFull;

  logic        bRstn, bReqValid, bReqReady, bCacheValid, bCacheReady, bLdValid, bLdConf, bErr;
  logic [31:0] bReqAddr, bCacheAddr, bLdAddr, bErrAddr;
  logic [63:0] bReqData, bCacheData;
  logic [1:0]  bReqSize, bLdSize;
  logic [7:0]  bWen;
  logic [2:0]  bCount;
  logic        bEmpty, bFull;

  dcache_store_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) uA (
    .clk(clk), .resetn(aRstn),
    .req_valid(aReqValid), .req_ready(aReqReady), .req_addr(aReqAddr),
    .req_size(aReqSize), .req_wdata(aReqData),
    .cache_req_valid(aCacheValid), .cache_req_ready(aCacheReady),
    .cache_addr(aCacheAddr), .cache_wen(aWen), .cache_wdata(aCacheData),
    .ld_valid(aLdValid), .ld_addr(aLdAddr), .ld_size(aLdSize), .ld_conflict(aLdConf),
    .st_addr_err(aErr), .st_err_addr(aErrAddr),
    .count(aCount), .empty(aEmpty), .full(aFull)
  );

  dcache_store_buffer #(.DEPTH(4), .DATA_W(64), .ADDR_W(32)) uB (
    .clk(clk), .resetn(bRstn),
    .req_valid(bReqValid), .req_ready(bReqReady), .req_addr(bReqAddr),
    .req_size(bReqSize), .req_wdata(bReqData),
    .cache_req_valid(bCacheValid), .cache_req_ready(bCacheReady),
    .cache_addr(bCacheAddr), .cache_wen(bWen), .cache_wdata(bCacheData),
    .ld_valid(bLdValid), .ld_addr(bLdAddr), .ld_size(bLdSize), .ld_conflict(bLdConf),
    .st_addr_err(bErr), .st_err_addr(bErrAddr),
    .count(bCount), .empty(bEmpty), .full(bFull)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aReq(input logic v, input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] d);
    aReqValid = v; aReqAddr = ad; aReqSize = sz; aReqData = d;
  endtask

  task automatic bReq(input logic v, input logic [31:0] ad, input logic [1:0] sz, input logic [63:0] d);
    bReqValid = v; bReqAddr = ad; bReqSize = sz; bReqData = d;
  endtask

  task automatic aHead(input string tag, input logic [31:0] ad, input logic [3:0] w, input logic [31:0] d);
    chk({tag, ".valid"}, 64'(aCacheValid), 64'd1);
    chk({tag, ".addr"},  64'(aCacheAddr), 64'(ad));
    chk({tag, ".wen"},   64'(aWen), 64'(w));
    chk({tag, ".data"},  64'(aCacheData), 64'(d));
  endtask

  initial begin
    aRstn = 0; bRstn = 0;
    aReq(0, 0, 0, 0); bReq(0, 0, 0, 0);
    aCacheReady = 0; bCacheReady = 0;
    aLdValid = 0; aLdAddr = 0; aLdSize = 0;
    bLdValid = 0; bLdAddr = 0; bLdSize = 0;
    #3;
    chk("rst.count", 64'(aCount), 64'd0);
    chk("rst.empty", 64'(aEmpty), 64'd1);
    chk("rst.full",  64'(aFull), 64'd0);
    chk("rst.ready", 64'(aReqReady), 64'd1);
    chk("rst.valid", 64'(aCacheValid), 64'd0);
    chk("rst.fields", {aCacheAddr, aCacheData} | 64'(aWen), 64'd0);
    chk("rst.err",   64'(aErr), 64'd0);
    chk("rst.erraddr", 64'(aErrAddr), 64'd0);
    tick();
    aRstn = 1; bRstn = 1;
    tick();

    // SB 0x1003 -> top lane
    aReq(1, 32'h1003, 2'b00, 32'hAB);
    tick();
    aReq(0, 0, 0, 0);
    aHead("sb", 32'h1000, 4'b1000, 32'hAB00_0000);
    chk("sb.count", 64'(aCount), 64'd1);
    aCacheReady = 1;
    tick();
    chk("sb.drain.empty", 64'(aEmpty), 64'd1);
    chk("sb.drain.valid", 64'(aCacheValid), 64'd0);
    aCacheReady = 0;

    // back-to-back misaligned: SW 0x2002 then dword on 32-bit cache
    aReq(1, 32'h2002, 2'b10, 32'h1111_1111);
    tick();
    chk("sw.mis.err", 64'(aErr), 64'd1);
    chk("sw.mis.erraddr", 64'(aErrAddr), 64'h2002);
    chk("sw.mis.count", 64'(aCount), 64'd0);
    aReq(1, 32'h5000, 2'b11, 32'h2222_2222);
    tick();
    chk("sd32.err", 64'(aErr), 64'd1);
    chk("sd32.erraddr", 64'(aErrAddr), 64'h5000);
    chk("sd32.count", 64'(aCount), 64'd0);
    aReq(0, 0, 0, 0);
    tick();
    chk("err.pulse.end", 64'(aErr), 64'd0);
    chk("err.addr.held", 64'(aErrAddr), 64'h5000);

    // SH 0x2002 is aligned
    aReq(1, 32'h2002, 2'b01, 32'h1234);
    tick();
    aReq(0, 0, 0, 0);
    aHead("sh", 32'h2000, 4'b1100, 32'h1234_0000);
    chk("sh.err", 64'(aErr), 64'd0);
    aCacheReady = 1;
    tick();
    aCacheReady = 0;
    chk("sh.drain.count", 64'(aCount), 64'd0);

    // fill to full with cache stalled
    for (int i = 0; i < 4; i++) begin
      aReq(1, 32'h100 + 32'(4 * i), 2'b10, 32'hA000_0000 + 32'(i));
      tick();
    end
    chk("fill.count", 64'(aCount), 64'd4);
    chk("fill.full",  64'(aFull), 64'd1);
    chk("fill.ready", 64'(aReqReady), 64'd0);
    aReq(1, 32'h110, 2'b10, 32'hA000_0004);
    tick();
    chk("fifth.wait.count", 64'(aCount), 64'd4);
    aHead("fifth.wait.head", 32'h100, 4'hF, 32'hA000_0000);
    // full + dequeue same cycle: enqueue still refused
    aCacheReady = 1;
    tick();
    chk("fulldeq.count", 64'(aCount), 64'd3);
    aHead("fulldeq.head", 32'h104, 4'hF, 32'hA000_0001);
    aReq(0, 0, 0, 0);
    tick();
    chk("deq.count", 64'(aCount), 64'd2);
    aReq(1, 32'h110, 2'b10, 32'hA000_0004);
    tick();
    aReq(0, 0, 0, 0);
    chk("enqdeq.count", 64'(aCount), 64'd2);
    aHead("enqdeq.head", 32'h10C, 4'hF, 32'hA000_0003);
    tick();
    aHead("wrap.head", 32'h110, 4'hF, 32'hA000_0004);
    tick();
    chk("wrap.empty", 64'(aEmpty), 64'd1);
    chk("wrap.valid", 64'(aCacheValid), 64'd0);
    aCacheReady = 0;

    // load conflict against buffered SH 0x3002
    aReq(1, 32'h3002, 2'b01, 32'hBEEF);
    tick();
    aReq(0, 0, 0, 0);
    aLdValid = 1; aLdAddr = 32'h3003; aLdSize = 2'b00;
    #1 chk("ld.lb3003", 64'(aLdConf), 64'd1);
    aLdAddr = 32'h3001;
    #1 chk("ld.lb3001", 64'(aLdConf), 64'd0);
    aLdAddr = 32'h3004; aLdSize = 2'b10;
    #1 chk("ld.lw3004", 64'(aLdConf), 64'd0);
    aLdAddr = 32'h3000;
    #1 chk("ld.lw3000", 64'(aLdConf), 64'd1);
    aLdValid = 0;
    #1 chk("ld.novalid", 64'(aLdConf), 64'd0);
    aCacheReady = 1;
    tick();
    aCacheReady = 0;
    aLdValid = 1;
    #1 chk("ld.afterdrain", 64'(aLdConf), 64'd0);
    aLdValid = 0;

    // 64-bit instance
    bReq(1, 32'h4008, 2'b11, 64'h1122_3344_5566_7788);
    tick();
    chk("sd.valid", 64'(bCacheValid), 64'd1);
    chk("sd.addr", 64'(bCacheAddr), 64'h4008);
    chk("sd.wen", 64'(bWen), 64'hFF);
    chk("sd.data", bCacheData, 64'h1122_3344_5566_7788);
    bReq(1, 32'h400C, 2'b10, 64'hCAFE_BABE);
    bCacheReady = 1;
    tick();
    bCacheReady = 0;
    chk("sw64.count", 64'(bCount), 64'd1);
    chk("sw64.addr", 64'(bCacheAddr), 64'h4008);
    chk("sw64.wen", 64'(bWen), 64'hF0);
    chk("sw64.data", bCacheData, 64'hCAFE_BABE_0000_0000);
    bReq(1, 32'h4004, 2'b11, 64'h5);
    tick();
    chk("sd64.mis.err", 64'(bErr), 64'd1);
    chk("sd64.mis.erraddr", 64'(bErrAddr), 64'h4004);
    chk("sd64.mis.count", 64'(bCount), 64'd1);
    bReq(1, 32'h4001, 2'b00, 64'h77);
    tick();
    bReq(0, 0, 0, 0);
    chk("sb64.count", 64'(bCount), 64'd2);
    bCacheReady = 1;
    tick();
    chk("sb64.head.wen", 64'(bWen), 64'h02);
    chk("sb64.head.data", bCacheData, 64'h7700);
    bRstn = 0;
    #1;
    chk("rst64.count", 64'(bCount), 64'd0);
    chk("rst64.valid", 64'(bCacheValid), 64'd0);
    chk("rst64.addr", 64'(bCacheAddr), 64'd0);
    chk("rst64.wen", 64'(bWen), 64'd0);
    chk("rst64.data", bCacheData, 64'd0);
    chk("rst64.err", {31'd0, bErr, bErrAddr}, 64'd0);
    chk("rst64.empty", 64'(bEmpty), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dcache_store_buffer.md
# dcache_store_buffer

Parametrised store buffer between the MEM stage and the data cache write port. Accepts committed stores, checks alignment, generates byte-lane write enables and lane-shifted write data, and queues them in a FIFO of DEPTH entries drained by a valid/ready handshake to the cache. It also flags loads that overlap a buffered store so the pipeline can stall. Misaligned stores are never queued; they raise a registered address-error pulse for CP0.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2
- DATA_W, 32: cache data width; 32 or 64
- ADDR_W, 32: address width
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  store request
- req_ready  out  1  buffer can accept (= !full)
- req_addr  in  ADDR_W  store byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- req_wdata  in  DATA_W  store data, right-justified (LSB-aligned)
- cache_req_valid  out  1  head entry valid
- cache_req_ready  in  1  cache accepts head entry
- cache_addr  out  ADDR_W  head address, low log2(DATA_W/8) bits zero
- cache_wen  out  DATA_W/8  head byte-lane enables
- cache_wdata  out  DATA_W  head lane-shifted data
- ld_valid  in  1  load lookup valid
- ld_addr  in  ADDR_W  load byte address
- ld_size  in  2  load size, same encoding
- ld_conflict  out  1  load overlaps a buffered store (combinational)
- st_addr_err  out  1  one-cycle misaligned-store pulse
- st_err_addr  out  ADDR_W  faulting address (BadVAddr), held until next error
- count  out  $clog2(DEPTH)+1  occupied entries
- empty / full  out  1 each  count==0 / count==DEPTH

## Operation
- Accept: req_valid && req_ready. OFF = log2(DATA_W/8); off = req_addr[OFF-1:0].
- Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0; any size 11 when DATA_W=32. Accepted misaligned request is consumed, not enqueued; next cycle st_addr_err=1 for one cycle, st_err_addr=req_addr.
- Aligned: base mask byte 1, half 3, word F, dword FF; cache_wen = base << off; cache_wdata = req_wdata << (8*off); cache_addr = req_addr with low OFF bits cleared. Entry written at tail, tail increments mod DEPTH.
- Dequeue: cache_req_valid && cache_req_ready; head increments mod DEPTH. Outputs come directly from head entry registers.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance. req_ready does not depend on cache_req_ready: a full buffer refuses even when dequeuing that cycle.
- ld_conflict = ld_valid && any valid entry with equal aligned address and (entry wen & load mask) ≠ 0, load mask computed like a store mask. Misaligned loads use the same formula (no error here). The store being enqueued in the same cycle is not checked.
- Overflow/underflow impossible by handshake; enqueue when full or dequeue when empty has no effect.

## Timing
- Reset (async, resetn=0): head=tail=0, count=0, empty=1, full=0, cache_req_valid=0, cache_addr=0, cache_wen=0, cache_wdata=0, st_addr_err=0, st_err_addr=0; all entry valid bits clear. Reset mid-operation discards all queued stores.
- Latency: store accepted at edge N into empty buffer → cache_req_valid=1 with its fields from N+1.
- Throughput: one enqueue and one dequeue per cycle.
- full asserted the cycle after the DEPTH-th enqueue without dequeue; req_ready low that same cycle.
- st_addr_err: exactly one cycle, edge after the accepting edge; back-to-back misaligned stores give back-to-back pulses, st_err_addr updates each.
- ld_conflict: combinational from ld_* and registered entries, no cycle delay.

## Test plan
- DATA_W=32: SB to 0x1003 data 0xAB → cache_wen=1000, cache_wdata=0xAB000000, cache_addr=0x1000 next cycle.
- SW to 0x2002 → not queued, count stays 0, st_addr_err=1 one cycle later, st_err_addr=0x2002; SH to 0x2002 → wen=1100.
- DEPTH=4, cache_req_ready=0, five stores → count=4, full=1, req_ready=0, fifth waits; raise ready → drained in order, pointers wrap, empty=1.
- Full buffer with enqueue attempt and dequeue same cycle → enqueue refused, count=3; at count=2, simultaneous enq+deq → count stays 2.
- Buffered SH 0x3002; load LB 0x3003 → ld_conflict=1; LB 0x3001 → 0; LW 0x3004 → 0.
- DATA_W=64: SD 0x4008 → wen=FF; SW 0x400C → wen=F0, data<<32; size 11 at 0x4004 → st_addr_err; assert resetn mid-drain → all outputs zero immediately.
